tapu_drain: RTL and testbench

Output-side collector for one TAPU tile: samples the per-column results leaving the PE array, removes the column skew in matrix-multiplication mode, and assembles one aligned `COLS`-wide row per cycle. Rows go into a small row FIFO that is drained over a valid/ready port toward the output buffer. The PE array cannot be back-pressured, so a FIFO overrun drops the row and sets a sticky flag.

---
 rtl/tapu_pkg.sv | 24 ++
 rtl/delay_chain.sv | 30 +++
 rtl/row_fifo.sv | 54 +++++
 rtl/tapu_drain.sv | 124 ++++++++++++
 tb/tb_tapu_drain.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tapu_pkg.sv
// Shared mode encodings and drain FSM state type for the TAPU output path.
package tapu_pkg;

    localparam logic [1:0] MODE_MATMUL = 2'b00;
    localparam logic [1:0] MODE_FPMUL  = 2'b10;
    localparam logic [1:0] MODE_FPADD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } drain_state_t;

    // Only matmul results leave the array skewed; 01 is handled like the fp modes.
    function automatic logic mode_is_skewed(input logic [1:0] mode);
        case (mode)
            MODE_MATMUL:            return 1'b1;
            MODE_FPMUL, MODE_FPADD: return 1'b0;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/delay_chain.sv
// Fixed-length register delay line with enable; DEPTH must be at least 1.
module delay_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/row_fifo.sv
// Registered row FIFO (no fall-through); a push into a full FIFO is accepted only alongside a pop.
module row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Gated so the head reads zero out of reset without resetting the storage array.
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tapu_drain.sv
// TAPU tile output collector: deskews PE-array column results into aligned rows and queues them.
module tapu_drain
    import tapu_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int BOTTOM_WIDTH = 48,
    parameter int DEPTH        = 8,
    parameter int ROW_W        = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_in,
    input  logic [1:0]                      mode_sel_in,
    input  logic [ROW_W-1:0]                num_rows_in,
    input  logic [COLS*BOTTOM_WIDTH-1:0]    z_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [COLS*BOTTOM_WIDTH-1:0]    out_data,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic [$clog2(DEPTH+1)-1:0]      fifo_level
);

    localparam int ROW_BITS  = COLS * BOTTOM_WIDTH;
    localparam int LEAD_W    = (COLS > 2) ? $clog2(COLS - 1) : 1;
    localparam int LEAD_INIT = (COLS > 1) ? COLS - 2 : 0;

    drain_state_t      state, state_nxt;
    logic              skewed_q;
    logic [ROW_W-1:0]  rows_left;
    logic [LEAD_W-1:0] lead_cnt;
    logic              push, pop, fifo_full, fifo_empty, start_ok;
    logic [ROW_BITS-1:0] skew_row, row_in;

    // Column c arrives c cycles late; delaying it by COLS-1-c lines every column up with the last.
    for (genvar c = 0; c < COLS - 1; c++) begin : g_deskew
        delay_chain #(
            .WIDTH(BOTTOM_WIDTH),
            .DEPTH(COLS - 1 - c)
        ) u_dly (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (1'b1),
            .d    (z_in[c*BOTTOM_WIDTH +: BOTTOM_WIDTH]),
            .q    (skew_row[c*BOTTOM_WIDTH +: BOTTOM_WIDTH])
        );
    end
    assign skew_row[(COLS-1)*BOTTOM_WIDTH +: BOTTOM_WIDTH] = z_in[(COLS-1)*BOTTOM_WIDTH +: BOTTOM_WIDTH];

    assign row_in   = skewed_q ? skew_row : z_in;
    assign start_ok = (state == ST_IDLE) && start_in;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_in) begin
                    if (num_rows_in == '0)                                state_nxt = ST_DONE;
                    else if (mode_is_skewed(mode_sel_in) && (COLS > 1))  state_nxt = ST_FILL;
                    else                                                  state_nxt = ST_STREAM;
                end
            end
            ST_FILL: begin
                if (lead_cnt == '0) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                push = 1'b1;
                if (rows_left == ROW_W'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            skewed_q  <= 1'b0;
            rows_left <= '0;
            lead_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                skewed_q  <= mode_is_skewed(mode_sel_in);
                rows_left <= num_rows_in;
                lead_cnt  <= LEAD_W'(LEAD_INIT);
            end else if (state == ST_FILL) begin
                lead_cnt  <= lead_cnt - LEAD_W'(1);
            end else if (state == ST_STREAM) begin
                rows_left <= rows_left - ROW_W'(1);
            end
            if (start_ok)                        overflow <= 1'b0;
            else if (push && fifo_full && !pop)  overflow <= 1'b1;
        end
    end

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    row_fifo #(
        .WIDTH(ROW_BITS),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(row_in),
        .full     (fifo_full),
        .pop      (pop),
        .pop_data (out_data),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_tapu_drain.sv
// Directed bench for tapu_drain: deskew timing, fp bypass, zero rows, overflow, full push+pop, reset.
module tb_tapu_drain;

    localparam int COLS     = 16;
    localparam int BW       = 48;
    localparam int DEPTH    = 8;
    localparam int ROW_W    = 8;
    localparam int LW       = $clog2(DEPTH+1);
    localparam int ROW_BITS = COLS * BW;

    logic                clk;
    logic                rst_n;
    logic                start_in;
    logic [1:0]          mode_sel_in;
    logic [ROW_W-1:0]    num_rows_in;
    logic [ROW_BITS-1:0] z_in;
    logic                out_valid;
    logic                out_ready;
    logic [ROW_BITS-1:0] out_data;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [LW-1:0]       fifo_level;

    tapu_drain #(
        .COLS        (COLS),
        .BOTTOM_WIDTH(BW),
        .DEPTH       (DEPTH),
        .ROW_W       (ROW_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_in   (start_in),
        .mode_sel_in(mode_sel_in),
        .num_rows_in(num_rows_in),
        .z_in       (z_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int S     = 0;
    int rows_cfg = 0;
    bit mm_cfg   = 1'b0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROW_BITS-1:0] exp_row(input int r);
        logic [ROW_BITS-1:0] row;
        for (int c = 0; c < COLS; c++) row[c*BW +: BW] = BW'(100*r + c);
        return row;
    endfunction

    task automatic chk_row();
        int r;
        logic [ROW_BITS-1:0] er;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_pop observed=%0h expected=none", out_data[BW-1:0]);
        end
        if (exp_q.size() != 0) begin
            r  = exp_q.pop_front();
            er = exp_row(r);
            total++;
            assert (out_data === er) else begin
                bad++;
                for (int c = 0; c < COLS; c++) begin
                    if (out_data[c*BW +: BW] !== er[c*BW +: BW]) begin
                        $error("FAIL row%0d_col%0d observed=%0h expected=%0h",
                               r, c, out_data[c*BW +: BW], er[c*BW +: BW]);
                        break;
                    end
                end
            end
        end
    endtask

    // Column c of row r sits on z_in at S+1+r+c (matmul) or S+1+r (fp).
    task automatic drive_z();
        int rel, r;
        rel = cyc - S;
        for (int c = 0; c < COLS; c++) begin
            r = mm_cfg ? rel - 1 - c : rel - 1;
            z_in[c*BW +: BW] = (r >= 0 && r < rows_cfg) ? BW'(100*r + c) : '0;
        end
    endtask

    task automatic step();
        if (out_valid === 1'b1 && out_ready === 1'b1) chk_row();
        @(posedge clk);
        #1;
        cyc++;
        drive_z();
    endtask

    task automatic start_cap(input logic [1:0] mode, input int rows);
        mode_sel_in = mode;
        num_rows_in = ROW_W'(rows);
        start_in    = 1'b1;
        S           = cyc;
        mm_cfg      = (mode == 2'b00);
        rows_cfg    = rows;
        step();
        start_in    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int rel;
        rst_n = 1'b0; start_in = 1'b0; mode_sel_in = 2'b00; num_rows_in = '0;
        z_in = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data[63:0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        rst_n = 1'b1;
        step(); step();

        // Matmul, 4 rows, consumer always ready
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) exp_q.push_back(r);
        start_cap(2'b00, 4);
        while (cyc - S <= 24) begin
            rel = cyc - S;
            case (rel)
                1:  chk("mm_busy", busy, 1);
                16: chk("mm_valid_early", out_valid, 0);
                17: chk("mm_valid_first", out_valid, 1);
                19: chk("mm_done_early", done, 0);
                20: chk("mm_done", done, 1);
                21: chk("mm_idle", busy, 0);
                default: ;
            endcase
            step();
        end
        chk("mm_all_popped", exp_q.size(), 0);

        // fp mul, 3 rows, unskewed
        for (int r = 0; r < 3; r++) exp_q.push_back(r);
        start_cap(2'b10, 3);
        while (cyc - S <= 8) begin
            rel = cyc - S;
            case (rel)
                1: chk("fp_valid_early", out_valid, 0);
                2: chk("fp_valid_first", out_valid, 1);
                3: begin chk("fp_done_early", done, 0); chk("fp_level", fifo_level, 1); end
                4: chk("fp_done", done, 1);
                default: ;
            endcase
            step();
        end
        chk("fp_all_popped", exp_q.size(), 0);

        // Zero rows
        start_cap(2'b00, 0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 1);
        chk("z_level", fifo_level, 0);
        step();
        chk("z_done_off", done, 0);
        chk("z_busy_off", busy, 0);
        chk("z_level2", fifo_level, 0);
        step();

        // Overflow: 10 rows into an 8-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) exp_q.push_back(r);
        start_cap(2'b10, 10);
        while (cyc - S <= 14) begin
            rel = cyc - S;
            case (rel)
                8:  chk("ov_level7", fifo_level, 7);
                9:  begin chk("ov_level8", fifo_level, 8); chk("ov_not_yet", overflow, 0); end
                10: chk("ov_set", overflow, 1);
                11: chk("ov_done", done, 1);
                14: begin chk("ov_level_hold", fifo_level, 8); chk("ov_sticky", overflow, 1); end
                default: ;
            endcase
            step();
        end

        // Full FIFO, push+pop each cycle; a second start while busy is ignored
        for (int r = 0; r < 3; r++) exp_q.push_back(r);
        start_cap(2'b11, 3);
        while (cyc - S <= 20) begin
            rel = cyc - S;
            case (rel)
                1: begin
                    out_ready = 1'b1;
                    chk("pp_ov_cleared", overflow, 0);
                    chk("pp_level_a", fifo_level, 8);
                end
                2: begin
                    chk("pp_level_b", fifo_level, 8);
                    start_in = 1'b1; num_rows_in = ROW_W'(5);
                end
                3: begin
                    start_in = 1'b0;
                    chk("pp_level_c", fifo_level, 8);
                end
                4: begin
                    chk("pp_done", done, 1);
                    chk("pp_level_d", fifo_level, 8);
                    chk("pp_no_ov", overflow, 0);
                end
                5: begin chk("pp_idle", busy, 0); chk("pp_level_e", fifo_level, 7); end
                default: ;
            endcase
            step();
        end
        chk("pp_all_popped", exp_q.size(), 0);
        chk("pp_level_empty", fifo_level, 0);

        // Reset in the middle of a matmul stream
        for (int r = 0; r < 4; r++) exp_q.push_back(r);
        start_cap(2'b00, 4);
        while (cyc - S < 18) step();
        chk("mr_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data[63:0], 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_overflow", overflow, 0);
        chk("mr_level", fifo_level, 0);
        exp_q.delete();
        step(); step();
        rst_n = 1'b1;
        step();

        // Fresh capture after reset
        for (int r = 0; r < 2; r++) exp_q.push_back(r);
        start_cap(2'b10, 2);
        while (cyc - S <= 8) begin
            rel = cyc - S;
            case (rel)
                2: chk("ar_valid", out_valid, 1);
                3: chk("ar_done", done, 1);
                default: ;
            endcase
            step();
        end
        chk("ar_all_popped", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
